// File: rtl/aes_pkg.sv
// Shared AES/Rijndael constants and helpers.
// Row offsets and legal block widths for the ShiftRows datapath.
package aes_pkg;

   localparam int BYTE_W  = 8;
   localparam int ROWS    = 4;
   localparam int COL_W   = BYTE_W * ROWS;

   localparam int NB_128  = 4;
   localparam int NB_192  = 6;
   localparam int NB_256  = 8;

   // Rijndael with 8 columns skips offset 2 on the lower rows
   function automatic int sr_offset(input int nb, input int row);
      if (nb == NB_256 && row >= 2)
         return row + 1;
      return row;
   endfunction

   function automatic bit nb_legal(input int nb);
      return nb == NB_128 || nb == NB_192 || nb == NB_256;
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Column-major state, byte k at data[8k+:8].
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [0:COL_W*NB-1] data,
   input  logic                inv,
   output logic [0:COL_W*NB-1] perm
);

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         localparam int S  = sr_offset(NB, r);
         localparam int FC = (c + S) % NB;
         localparam int IC = (c - S + NB) % NB;
         localparam int OB = BYTE_W * (c * ROWS + r);
         localparam int FB = BYTE_W * (FC * ROWS + r);
         localparam int IB = BYTE_W * (IC * ROWS + r);

         assign perm[OB +: BYTE_W] = inv ?
            data[IB +: BYTE_W] :
            data[FB +: BYTE_W];
      end
   end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows stage: permute on input, registered
// output plus one skid entry for full-rate back-pressure.
module shift_rows_stream
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:32*NB-1]   in_data,
   input  logic               in_inv,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:32*NB-1]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_inv,
   output logic [15:0]        xfer_cnt
);

   localparam int W = 32 * NB;

   if (!nb_legal(NB)) begin : g_nb_chk
      $error("shift_rows_stream: NB must be 4, 6 or 8");
   end

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             inv;
      logic [0:W-1]     data;
   } entry_t;

   logic [0:W-1] perm;
   entry_t       inc;
   entry_t       main_q, main_d;
   entry_t       skid_q, skid_d;
   logic         main_v_q, main_v_d;
   logic         skid_v_q, skid_v_d;
   logic         rdy_q;
   logic         acc;

   shift_rows_perm #(.NB(NB)) u_perm (
      .data (in_data),
      .inv  (in_inv),
      .perm (perm)
   );

   assign inc = '{tag: in_tag, inv: in_inv, data: perm};
   assign acc = in_valid & rdy_q;

   // main drains first; skid only fills while main is stalled
   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (!main_v_q || out_ready) begin
         if (skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            if (acc)
               skid_d = inc;
            else
               skid_v_d = 1'b0;
         end else begin
            main_v_d = acc;
            if (acc)
               main_d = inc;
         end
      end else if (acc) begin
         skid_d   = inc;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         rdy_q    <= !skid_v_d;
         xfer_cnt <= xfer_cnt + 16'(acc);
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = main_v_q;
   assign out_data  = main_q.data;
   assign out_tag   = main_q.tag;
   assign out_inv   = main_q.inv;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Scoreboard bench for shift_rows_stream, NB=4 and NB=8 instances.
// Directed vectors with hand-computed expected states.
module tb_shift_rows_stream;

   typedef struct {
      logic [3:0]   tag;
      logic         inv;
      logic [255:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic           in_valid4, in_ready4, in_inv4;
   logic [0:127]   in_data4, out_data4;
   logic [3:0]     in_tag4, out_tag4;
   logic           out_valid4, out_ready4, out_inv4;
   logic [15:0]    xfer4;

   logic           in_valid8, in_ready8, in_inv8;
   logic [0:255]   in_data8, out_data8;
   logic [3:0]     in_tag8, out_tag8;
   logic           out_valid8, out_ready8, out_inv8;
   logic [15:0]    xfer8;

   exp_t q4[$];
   exp_t q8[$];
   logic mon4_en = 1'b1;

   logic         hold_v = 1'b0;
   logic [0:127] hold_d;
   logic [3:0]   hold_t;
   logic         hold_i;

   logic [0:127] vin[4];
   logic [0:127] vexp[4];
   logic         vinv[4];

   shift_rows_stream #(.NB(4), .TAG_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
      .in_inv    (in_inv4),
      .in_tag    (in_tag4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_data  (out_data4),
      .out_tag   (out_tag4),
      .out_inv   (out_inv4),
      .xfer_cnt  (xfer4)
   );

   shift_rows_stream #(.NB(8), .TAG_W(4)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_data   (in_data8),
      .in_inv    (in_inv8),
      .in_tag    (in_tag8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_data  (out_data8),
      .out_tag   (out_tag8),
      .out_inv   (out_inv8),
      .xfer_cnt  (xfer8)
   );

   task automatic chk(input string nm,
                      input logic [255:0] act,
                      input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting on DUT", nm);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && mon4_en && out_valid4 && out_ready4) begin
         if (q4.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL m4_spurious: got tag %0d want none",
                     out_tag4);
         end else begin
            e = q4.pop_front();
            chk("m4_tag", 256'(out_tag4), 256'(e.tag));
            chk("m4_inv", 256'(out_inv4), 256'(e.inv));
            chk("m4_data", 256'(out_data4), e.d);
         end
      end
      if (rst && hold_v) begin
         chk("stall_valid", 256'(out_valid4), 256'(1));
         chk("stall_data", 256'(out_data4), 256'(hold_d));
         chk("stall_tag", 256'(out_tag4), 256'(hold_t));
         chk("stall_inv", 256'(out_inv4), 256'(hold_i));
      end
      hold_v = rst && out_valid4 && !out_ready4;
      hold_d = out_data4;
      hold_t = out_tag4;
      hold_i = out_inv4;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst && out_valid8 && out_ready8) begin
         if (q8.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL m8_spurious: got tag %0d want none",
                     out_tag8);
         end else begin
            e = q8.pop_front();
            chk("m8_tag", 256'(out_tag8), 256'(e.tag));
            chk("m8_inv", 256'(out_inv8), 256'(e.inv));
            chk("m8_data", 256'(out_data8), e.d);
         end
      end
   end

   // callers are aligned 1 time unit after a rising edge
   task automatic send4(input logic [0:127] d,
                        input logic inv,
                        input logic [3:0] tag,
                        input logic [0:127] e);
      int n;
      exp_t x;
      n = 0;
      while (!in_ready4 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready4) begin
         timeout("send4_ready");
         return;
      end
      in_valid4 = 1'b1;
      in_data4  = d;
      in_inv4   = inv;
      in_tag4   = tag;
      x.tag = tag;
      x.inv = inv;
      x.d   = 256'(e);
      q4.push_back(x);
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
   endtask

   task automatic send8(input logic [0:255] d,
                        input logic inv,
                        input logic [3:0] tag,
                        input logic [0:255] e);
      int n;
      exp_t x;
      n = 0;
      while (!in_ready8 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready8) begin
         timeout("send8_ready");
         return;
      end
      in_valid8 = 1'b1;
      in_data8  = d;
      in_inv8   = inv;
      in_tag8   = tag;
      x.tag = tag;
      x.inv = inv;
      x.d   = 256'(e);
      q8.push_back(x);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
   endtask

   task automatic drain4(input string nm);
      int n;
      n = 0;
      while (q4.size() != 0 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, 256'(q4.size()), 256'(0));
   endtask

   initial begin
      vin[0]  = 128'hd42711aee0bf98f1b8b45de51e415230;
      vinv[0] = 1'b0;
      vexp[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      vin[1]  = 128'h000102030405060708090a0b0c0d0e0f;
      vinv[1] = 1'b0;
      vexp[1] = 128'h00050a0f04090e03080d02070c01060b;
      vin[2]  = 128'h000102030405060708090a0b0c0d0e0f;
      vinv[2] = 1'b1;
      vexp[2] = 128'h000d0a0704010e0b0805020f0c090603;
      vin[3]  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      vinv[3] = 1'b1;
      vexp[3] = 128'hd42711aee0bf98f1b8b45de51e415230;

      in_valid4 = 0; in_inv4 = 0; in_tag4 = 0; in_data4 = '0;
      in_valid8 = 0; in_inv8 = 0; in_tag8 = 0; in_data8 = '0;
      out_ready4 = 1'b1;
      out_ready8 = 1'b1;

      #1;
      chk("rst_out_valid", 256'(out_valid4), 256'(0));
      chk("rst_in_ready", 256'(in_ready4), 256'(0));
      chk("rst_xfer", 256'(xfer4), 256'(0));
      chk("rst_out_data", 256'(out_data4), 256'(0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_in_ready", 256'(in_ready4), 256'(1));

      // FIPS-197 round 1 with one-cycle latency
      send4(vin[0], vinv[0], 4'd1, vexp[0]);
      chk("lat_valid", 256'(out_valid4), 256'(1));
      chk("lat_data", 256'(out_data4), 256'(vexp[0]));
      for (int i = 1; i < 4; i++)
         send4(vin[i], vinv[i], 4'(i + 1), vexp[i]);
      send4(vexp[1], 1'b1, 4'd5, vin[1]);
      drain4("drain_dir");

      send8(256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f,
            1'b0, 4'd6,
            256'h00050e1304091217080d161b0c111a1f_10151e0314190207181d060b1c010a0f);
      send8(256'h00050e1304091217080d161b0c111a1f_10151e0314190207181d060b1c010a0f,
            1'b1, 4'd7,
            256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f);
      repeat (3) @(posedge clk);
      #1;
      chk("drain8", 256'(q8.size()), 256'(0));
      chk("xfer8", 256'(xfer8), 256'(2));

      // back-to-back stream with a 3-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 10; i++)
               send4(vin[i % 4], vinv[i % 4], 4'(i), vexp[i % 4]);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready4 = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_in_ready_low", 256'(in_ready4), 256'(0));
            repeat (2) @(posedge clk);
            #1 out_ready4 = 1'b1;
         end
      join
      drain4("drain_bp");
      chk("bp_xfer", 256'(xfer4), 256'(15));

      // reset with both main and skid occupied
      out_ready4 = 1'b0;
      send4(vin[1], 1'b0, 4'd11, vexp[1]);
      send4(vin[2], 1'b1, 4'd12, vexp[2]);
      chk("pre_rst_full", 256'(in_ready4), 256'(0));
      #2 rst = 1'b0;
      q4.delete();
      #1;
      chk("mid_rst_valid", 256'(out_valid4), 256'(0));
      chk("mid_rst_xfer", 256'(xfer4), 256'(0));
      chk("mid_rst_ready", 256'(in_ready4), 256'(0));
      chk("mid_rst_data", 256'(out_data4), 256'(0));
      chk("mid_rst_tag", 256'(out_tag4), 256'(0));
      out_ready4 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 256'(in_ready4), 256'(1));
      for (int i = 0; i < 3; i++) begin
         chk("no_stale", 256'(out_valid4), 256'(0));
         @(posedge clk);
         #1;
      end

      // counter wrap over 65537 accepts
      mon4_en = 1'b0;
      in_data4 = vin[1];
      in_inv4  = 1'b0;
      in_valid4 = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      chk("xfer_ffff", 256'(xfer4), 256'(16'hffff));
      repeat (2) @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      chk("xfer_wrap", 256'(xfer4), 256'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
Parametrised, streaming ShiftRows / InvShiftRows unit for the AES/Rijndael datapath. It supports Rijndael block widths of 4, 6 or 8 columns and a per-transaction encrypt/decrypt mode. It uses a valid/ready handshake with a one-cycle registered output and a skid register, so full throughput survives downstream back-pressure. It sits between sub_bytes and mix_columns in both cipher and inverse-cipher round pipelines.

Parameters:
NB, 4, state columns; legal values are 4, 6 and 8. Block width W = 32*NB.
TAG_W, 4, width of the sideband tag (round number or key slot) carried alongside each state.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input state present
in_ready  out  1  block can accept a state this cycle
in_data  in  [0:W-1]  state, column-major; byte k = in_data[8k+:8], column k/4, row k%4
in_inv  in  1  0 = ShiftRows (left), 1 = InvShiftRows (right)
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  output state present
out_ready  in  1  downstream accepts
out_data  out  [0:W-1]  shifted state, same byte layout
out_tag  out  TAG_W  tag of the state on out_data
out_inv  out  1  mode the state was processed with
xfer_cnt  out  16  count of accepted input transfers, wraps at 2^16

Behaviour:
- Row offsets s_r, r = 0..3: NB=4 or 6 gives 0,1,2,3. NB=8 gives 0,1,3,4.
- Forward: out[col c, row r] = in[col (c+s_r) mod NB, row r].
- Inverse: out[col c, row r] = in[col (c−s_r+NB) mod NB, row r].
- The permutation is combinational on the input side. Only handshake and storage logic is registered.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Storage has two slots:
  - Main output register: drives the out_* ports.
  - Skid register: holds one extra entry.
- in_ready is registered: in_ready = !skid_full.
- Latency: exactly 1 cycle from accept to out_valid when the pipe is empty.
- Throughput: 1 state/cycle while out_ready = 1.
- Cycle rules:
  - Output empty, or output transferring this cycle: an accepted state loads the main register. If the skid is full, the skid entry moves to main instead, and any accepted state moves into the skid.
  - Output full and out_ready = 0: an accepted state loads the skid. in_ready falls the next cycle.
  - Skid full and out_ready = 0: in_ready = 0, and everything holds.
  - Accept and output transfer in the same cycle with the skid empty: main is replaced. No bubble, and the skid stays empty.
- Ordering is strictly FIFO. No state is dropped or duplicated.
- out_data, out_tag and out_inv stay stable while out_valid = 1 and out_ready = 0.
- xfer_cnt increments on each input accept and wraps 0xFFFF → 0x0000.
- Reset (rst = 0, asynchronous; may assert mid-transfer):
  - out_valid = 0, out_data = 0, out_tag = 0, out_inv = 0.
  - Skid empty, xfer_cnt = 0, in_ready = 0 while in reset.
  - in_ready = 1 on the first clock after deassertion.
  - All in-flight states are discarded.
- Illegal NB is a hard elaboration error, raised by a generate-time check.

Decomposition:
- Package aes_pkg:
  - byte-slice constants;
  - function sr_offset(nb, row) returning s_r;
  - legal-NB constants.
- Sub-module shift_rows_perm (combinational). Parameter NB; inputs data and inv; output permuted data. It is reused later by the key-expansion test model.
- The handshake and skid logic stays in shift_rows_stream.

Test Plan:
- FIPS-197 B round 1, NB=4, inv=0: d42711aee0bf98f1b8b45de51e415230 → out d4bf5d30e0b452aeb84111f11e2798e5, one cycle after accept.
- NB=4, bytes 00..0f: inv=0 → 00050a0f04090e03080d02070c01060b. Feeding that back with inv=1 → 000102…0f.
- NB=8, bytes 00..1f, inv=0: column 0 of the output = 00 05 0e 13. Applying inv=1 restores the input exactly.
- Back-pressure:
  - 10 back-to-back states with tags 0..9; hold out_ready = 0 for 3 cycles mid-stream.
  - in_ready drops after two states are stored.
  - Out order is tags 0..9, none lost, and output is stable while stalled.
- Reset mid-stream: assert rst while main and skid are full → out_valid = 0, xfer_cnt = 0 immediately. After release, in_ready = 1 next clock and no stale state appears.
- Counter wrap: 65537 accepts → xfer_cnt = 1.
